zipo_ram: RTL and testbench

- Parametrised, synchronous, single-port data/instruction memory for the zipocpu system.
- Successor to the fixed 64-bit CPU-side RAM model. Adds:
  - configurable data width, depth and base address
  - byte-enable writes
  - a valid/ready request handshake with programmable wait states
  - a registered response, and an exception flag for out-of-range or misaligned accesses
- Sits between the zipocpu bus port and backing storage; usable in simulation and synthesis.

---
 rtl/zipo_pkg.sv | 22 ++
 rtl/zipo_ram_array.sv | 33 +++
 rtl/zipo_ram.sv | 134 +++++++++++++
 tb/tb_zipo_ram.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/zipo_pkg.sv
// Shared constants for the zipocpu RAM: default geometry, FSM state encoding
// and the rw request encoding.
package zipo_pkg;

  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ADDR_W = 64;
  localparam int unsigned MEM_DEPTH  = 1024;
  localparam logic [MEM_ADDR_W-1:0] MEM_BASE = '0;
  // Last valid byte address of the default-sized memory.
  localparam logic [MEM_ADDR_W-1:0] MEM_END =
      MEM_BASE + MEM_ADDR_W'(MEM_DEPTH * (MEM_DATA_W / 8)) - MEM_ADDR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } zipo_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/zipo_ram_array.sv
// Storage array for zipo_ram: byte-enabled synchronous write, registered read.
// Kept separate so it can be replaced by an SRAM macro.
module zipo_ram_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic                re,
  input  logic [IDX_W-1:0]    index,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(DATA_W / 8); i++) begin
        if (byte_en[i]) begin
          mem[index][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/zipo_ram.sv
// Single-port RAM with valid/ready request, programmable wait states and a
// registered response. ZIPO_RAM_ALIGN_CHECK_EN makes misaligned accesses fault.
module zipo_ram
  import zipo_pkg::*;
#(
  parameter int unsigned          DATA_W      = MEM_DATA_W,
  parameter int unsigned          ADDR_W      = MEM_ADDR_W,
  parameter int unsigned          DEPTH       = MEM_DEPTH,
  parameter logic [ADDR_W-1:0]    BASE_ADDR   = '0,
  parameter int unsigned          WAIT_STATES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                rw,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   write,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic [DATA_W-1:0]   read,
  output logic                resp_valid,
  output logic                exception
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  zipo_state_e         state_q;
  logic [3:0]          wait_cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rw_q;
  logic [DATA_W-1:0]   write_q;
  logic [BYTES-1:0]    byte_en_q;
  logic                read_sel_q;

  logic [ADDR_W-1:0]   offset;
  logic [ADDR_W-1:0]   index_full;
  logic [IDX_W-1:0]    index;
  logic                range_fault;
  logic                misaligned;
  logic                fault;
  logic                arr_we;
  logic                arr_re;
  logic [DATA_W-1:0]   arr_rdata;

  assign offset      = addr_q - BASE_ADDR;
  assign index_full  = offset >> OFF_W;
  assign index       = index_full[IDX_W-1:0];
  assign range_fault = (addr_q < BASE_ADDR) || (index_full >= ADDR_W'(DEPTH));

`ifdef ZIPO_RAM_ALIGN_CHECK_EN
  assign misaligned = (addr_q & ADDR_W'(BYTES - 1)) != '0;
`else
  assign misaligned = 1'b0;
`endif

  assign fault = range_fault | misaligned;

  // Array is touched only in RESP, and never on a reset cycle.
  assign arr_we = (state_q == ST_RESP) && !rst && !fault && (rw_q == RW_WRITE);
  assign arr_re = (state_q == ST_RESP) && !rst && !fault && (rw_q == RW_READ);

  zipo_ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .we      (arr_we),
    .re      (arr_re),
    .index   (index),
    .wdata   (write_q),
    .byte_en (byte_en_q),
    .rdata   (arr_rdata)
  );

  // The array's read register holds between reads; writes and faults show zero.
  assign read = read_sel_q ? arr_rdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      exception  <= 1'b0;
      read_sel_q <= 1'b0;
      addr_q     <= '0;
      rw_q       <= RW_READ;
      write_q    <= '0;
      byte_en_q  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= addr;
            rw_q      <= rw;
            write_q   <= write;
            byte_en_q <= byte_en;
            req_ready <= 1'b0;
            if (WAIT_STATES == 0) begin
              state_q <= ST_RESP;
            end else begin
              state_q    <= ST_WAIT;
              wait_cnt_q <= 4'(WAIT_STATES);
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 4'd1) begin
            state_q    <= ST_RESP;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          resp_valid <= 1'b1;
          exception  <= fault;
          read_sel_q <= !fault && (rw_q == RW_READ);
          req_ready  <= 1'b1;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q   <= ST_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zipo_ram.sv
// Randomized self-checking bench for zipo_ram against a word-array model.
module tb_zipo_ram;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 64;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS    = 2;
  localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
`ifdef ZIPO_RAM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        rw;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [63:0] rdata;
  logic        resp_valid;
  logic        exception;

  zipo_ram #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .BASE_ADDR   (BASE),
    .WAIT_STATES (WS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .rw         (rw),
    .addr       (addr),
    .write      (wdata),
    .byte_en    (be),
    .read       (rdata),
    .resp_valid (resp_valid),
    .exception  (exception)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] model [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_fault(input logic [63:0] a);
    logic [63:0] off;
    if (a < BASE) return 1'b1;
    off = a - BASE;
    if ((off / 8) >= 64'(DEPTH)) return 1'b1;
    if (ALIGN && (a % 8) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One complete request/response, checked against the model.
  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input logic [7:0] b, output logic [63:0] rd);
    bit          f;
    int          idx;
    int          lat;
    bit          seen;
    logic [63:0] exp_rd;
    f      = is_fault(a);
    idx    = f ? 0 : int'((a - BASE) / 8);
    exp_rd = (!f && !w) ? model[idx] : 64'h0;
    rd     = 64'h0;
    @(negedge clk);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'h1);
    req_valid = 1'b1;
    rw        = w;
    addr      = a;
    wdata     = d;
    be        = b;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    addr      = {$urandom, $urandom};
    wdata     = {$urandom, $urandom};
    check("req_ready_busy", 64'(req_ready), 64'h0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = resp_valid;
    end
    check("resp_latency", 64'(lat), 64'(WS + 1));
    if (seen) begin
      rd = rdata;
      check("exception", 64'(exception), 64'(f));
      check("read_data", rdata, exp_rd);
      @(negedge clk);
      check("resp_one_cycle", 64'(resp_valid), 64'h0);
      check("read_hold", rdata, exp_rd);
    end
    if (!f && w) begin
      for (int i = 0; i < 8; i++) begin
        if (b[i]) model[idx][8*i +: 8] = d[8*i +: 8];
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic [63:0] old5;
    bit          rv_seen;
    rst       = 1'b1;
    req_valid = 1'b1;
    rw        = 1'b1;
    addr      = BASE;
    wdata     = 64'hDEAD_BEEF_DEAD_BEEF;
    be        = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'h1);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_read", rdata, 64'h0);
      check("rst_exception", 64'(exception), 64'h0);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("post_rst_no_resp", 64'(resp_valid), 64'h0);

    // Fill the words the random phase touches.
    for (int i = 0; i < 16; i++) xact(1'b1, BASE + 64'(8 * i), {$urandom, $urandom}, 8'hFF, rd);
    xact(1'b1, BASE + 64'(8 * (DEPTH - 1)), {$urandom, $urandom}, 8'hFF, rd);

    xact(1'b1, BASE + 64'd8, 64'h1122334455667788, 8'hFF, rd);
    xact(1'b0, BASE + 64'd8, 64'h0, 8'h00, rd);
    check("full_word", rd, 64'h1122334455667788);
    xact(1'b1, BASE + 64'd8, 64'hAAAAAAAAAAAAAAAA, 8'h0F, rd);
    xact(1'b0, BASE + 64'd8, 64'h0, 8'h00, rd);
    check("partial_word", rd, 64'h11223344AAAAAAAA);
    xact(1'b1, BASE + 64'd8, 64'h5555555555555555, 8'h00, rd);
    xact(1'b0, BASE + 64'd8, 64'h0, 8'h00, rd);
    check("no_byte_en", rd, 64'h11223344AAAAAAAA);

    xact(1'b0, BASE + 64'(8 * DEPTH), 64'h0, 8'h00, rd);
    xact(1'b1, BASE + 64'(8 * DEPTH), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, rd);
    xact(1'b0, BASE, 64'h0, 8'h00, rd);
    xact(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'h0, 8'h00, rd);
    xact(1'b0, BASE - 64'd8, 64'h0, 8'h00, rd);
    xact(1'b0, BASE + 64'd3, 64'h0, 8'h00, rd);

    // Reset while waiting on a write must abort it without a response.
    old5 = model[5];
    @(negedge clk);
    for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
    req_valid = 1'b1;
    rw        = 1'b1;
    addr      = BASE + 64'd40;
    wdata     = ~old5;
    be        = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    rv_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1'b1;
    end
    check("abort_no_resp", 64'(rv_seen), 64'h0);
    check("abort_ready", 64'(req_ready), 64'h1);
    xact(1'b0, BASE + 64'd40, 64'h0, 8'h00, rd);
    check("abort_old_value", rd, old5);

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic [63:0] a;
      kind = $urandom_range(0, 9);
      if (kind == 0) a = BASE + 64'(8 * (DEPTH + $urandom_range(0, 100)));
      else if (kind == 1) a = BASE - 64'd1 - 64'($urandom_range(0, 255));
      else a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'((kind == 2) ? $urandom_range(0, 7) : 0);
      xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom), rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
